te_block_sequencer: RTL and testbench

- Drains uop_entry_s records from the connector's uop FIFO and groups consecutive retired instructions into trace blocks.
- Accumulates the retired half-word count (iretire) until a block-closing event occurs: non-STD itype, privilege change, or counter limit.
- Attaches exc_info_s from the exception FIFO for EXC/INT blocks.
- Sits between the uop/exc FIFOs and the trace encoder input, with valid/ready on every side.

---
 rtl/connector_pkg.sv | 63 ++++++
 rtl/te_block_sequencer.sv | 146 ++++++++++++++
 tb/tb_te_block_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/connector_pkg.sv
// Shared types for the trace connector: FIFO records, the trace block
// bundle, the sequencer FSM encoding and the uop size helper.
package connector_pkg;

`ifdef TE_ARCH64
   localparam int unsigned XLEN = 64;
`else
   localparam int unsigned XLEN = 32;
`endif
   localparam int unsigned ITYPE_LEN = 4;
   localparam int unsigned PRIV_LEN  = 2;
   // Storage width of the retire counter; the sequencer may limit it lower.
   localparam int unsigned IRETIRE_W = 32;

   localparam logic [ITYPE_LEN-1:0] ITYPE_STD  = 4'd0;
   localparam logic [ITYPE_LEN-1:0] ITYPE_EXC  = 4'd1;
   localparam logic [ITYPE_LEN-1:0] ITYPE_INT  = 4'd2;
   localparam logic [ITYPE_LEN-1:0] ITYPE_ERET = 4'd3;
   localparam logic [ITYPE_LEN-1:0] ITYPE_NTB  = 4'd4;
   localparam logic [ITYPE_LEN-1:0] ITYPE_TB   = 4'd5;
   localparam logic [ITYPE_LEN-1:0] ITYPE_RET  = 4'd13;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_e;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_COUNT,
      SEQ_WAIT_EXC,
      SEQ_EMIT
   } seq_state_e;

   typedef struct packed {
      logic                 valid;
      logic [XLEN-1:0]      pc;
      logic [ITYPE_LEN-1:0] itype;
      logic [PRIV_LEN-1:0]  priv;
      logic                 compressed;
   } uop_entry_s;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
   } exc_info_s;

   typedef struct packed {
      logic [XLEN-1:0]      iaddr;
      logic [IRETIRE_W-1:0] iretire;
      logic                 ilastsize;
      logic [ITYPE_LEN-1:0] itype;
      logic [PRIV_LEN-1:0]  priv;
      logic [XLEN-1:0]      cause;
      logic [XLEN-1:0]      tval;
   } te_block_s;

   // Half-words retired by one instruction.
   function automatic logic [1:0] uop_size(input logic compressed);
      return compressed ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/te_block_sequencer.sv
// Groups retired uops into trace blocks for the encoder.
// Ports: uop FIFO (valid/entry/ready), exc FIFO (valid/info/ready),
// block output (valid/ready plus iaddr/iretire/ilastsize/itype/priv/cause/tval).
module te_block_sequencer
   import connector_pkg::*;
#(
   parameter int unsigned IRETIRE_LEN = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   uop_valid_i,
   input  uop_entry_s             uop_entry_i,
   output logic                   uop_ready_o,
   input  logic                   exc_valid_i,
   input  exc_info_s              exc_info_i,
   output logic                   exc_ready_o,
   output logic                   block_valid_o,
   input  logic                   block_ready_i,
   output logic [XLEN-1:0]        iaddr_o,
   output logic [IRETIRE_LEN-1:0] iretire_o,
   output logic                   ilastsize_o,
   output logic [ITYPE_LEN-1:0]   itype_o,
   output logic [PRIV_LEN-1:0]    priv_o,
   output logic [XLEN-1:0]        cause_o,
   output logic [XLEN-1:0]        tval_o
);

   localparam logic [63:0] IRET_MAX = (64'd1 << IRETIRE_LEN) - 64'd1;

   seq_state_e state_q, state_d;
   te_block_s  block_q, block_d;
   // pend_q.valid doubles as the pending-entry flag.
   uop_entry_s pend_q, pend_d;

   logic        uop_pop;
   logic        exc_pop;
   logic        blk_hs;
   logic [1:0]  pop_size;
   logic [63:0] iret_sum;
   logic        over_limit;
   logic        priv_change;

   function automatic te_block_s open_block(input uop_entry_s e);
      te_block_s b;
      b           = '0;
      b.iaddr     = e.pc;
      b.iretire   = IRETIRE_W'(uop_size(e.compressed));
      b.ilastsize = ~e.compressed;
      b.itype     = e.itype;
      b.priv      = e.priv;
      return b;
   endfunction

   function automatic seq_state_e open_state(
      input logic [ITYPE_LEN-1:0] it
   );
      if (it == ITYPE_STD) return SEQ_COUNT;
      if (it == ITYPE_EXC || it == ITYPE_INT) return SEQ_WAIT_EXC;
      return SEQ_EMIT;
   endfunction

   assign uop_ready_o = ((state_q == SEQ_IDLE) ||
                         (state_q == SEQ_COUNT)) && !pend_q.valid;
   assign exc_ready_o   = (state_q == SEQ_WAIT_EXC);
   assign block_valid_o = (state_q == SEQ_EMIT);

   assign uop_pop = uop_valid_i && uop_ready_o;
   assign exc_pop = exc_valid_i && exc_ready_o;
   assign blk_hs  = block_valid_o && block_ready_i;

   assign pop_size    = uop_size(uop_entry_i.compressed);
   assign iret_sum    = 64'(block_q.iretire) + 64'(pop_size);
   assign over_limit  = iret_sum > IRET_MAX;
   assign priv_change = uop_entry_i.priv != block_q.priv;

   always_comb begin
      state_d = state_q;
      block_d = block_q;
      pend_d  = pend_q;
      unique case (state_q)
         SEQ_IDLE: begin
            if (uop_pop && uop_entry_i.valid) begin
               block_d = open_block(uop_entry_i);
               state_d = open_state(uop_entry_i.itype);
            end
         end
         SEQ_COUNT: begin
            if (uop_pop && uop_entry_i.valid) begin
               if (priv_change || over_limit) begin
                  // Close what we have; the new uop opens the next block.
                  block_d.itype = ITYPE_STD;
                  pend_d        = uop_entry_i;
                  state_d       = SEQ_EMIT;
               end else begin
                  block_d.iretire   = IRETIRE_W'(iret_sum);
                  block_d.ilastsize = ~uop_entry_i.compressed;
                  block_d.itype     = uop_entry_i.itype;
                  state_d           = open_state(uop_entry_i.itype);
               end
            end
         end
         SEQ_WAIT_EXC: begin
            if (exc_pop) begin
               block_d.cause = exc_info_i.cause;
               block_d.tval  = exc_info_i.tval;
               state_d       = SEQ_EMIT;
            end
         end
         SEQ_EMIT: begin
            if (blk_hs) begin
               if (pend_q.valid) begin
                  block_d      = open_block(pend_q);
                  state_d      = open_state(pend_q.itype);
                  pend_d.valid = 1'b0;
               end else begin
                  block_d.cause = '0;
                  block_d.tval  = '0;
                  state_d       = SEQ_IDLE;
               end
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SEQ_IDLE;
         block_q <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         block_q <= block_d;
         pend_q  <= pend_d;
      end
   end

   assign iaddr_o     = block_q.iaddr;
   assign iretire_o   = block_q.iretire[IRETIRE_LEN-1:0];
   assign ilastsize_o = block_q.ilastsize;
   assign itype_o     = block_q.itype;
   assign priv_o      = block_q.priv;
   assign cause_o     = block_q.cause;
   assign tval_o      = block_q.tval;

endmodule

// File: tb/tb_te_block_sequencer.sv
// Bench for te_block_sequencer: directed scenarios plus random uop streams
// checked against a stream-level block model.
module tb_te_block_sequencer;
   import connector_pkg::*;

   localparam int IRL  = 4;
   localparam int ILIM = (1 << IRL) - 1;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             uop_valid_i;
   uop_entry_s       uop_entry_i;
   logic             uop_ready_o;
   logic             exc_valid_i;
   exc_info_s        exc_info_i;
   logic             exc_ready_o;
   logic             block_valid_o;
   logic             block_ready_i;
   logic [XLEN-1:0]  iaddr_o;
   logic [IRL-1:0]   iretire_o;
   logic             ilastsize_o;
   logic [ITYPE_LEN-1:0] itype_o;
   logic [PRIV_LEN-1:0]  priv_o;
   logic [XLEN-1:0]  cause_o;
   logic [XLEN-1:0]  tval_o;

   te_block_sequencer #(.IRETIRE_LEN(IRL)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .uop_valid_i(uop_valid_i), .uop_entry_i(uop_entry_i),
      .uop_ready_o(uop_ready_o),
      .exc_valid_i(exc_valid_i), .exc_info_i(exc_info_i),
      .exc_ready_o(exc_ready_o),
      .block_valid_o(block_valid_o), .block_ready_i(block_ready_i),
      .iaddr_o(iaddr_o), .iretire_o(iretire_o),
      .ilastsize_o(ilastsize_o), .itype_o(itype_o), .priv_o(priv_o),
      .cause_o(cause_o), .tval_o(tval_o)
   );

   always #5 clk_i = ~clk_i;

   int vectors = 0;
   int miscompares = 0;
   int uop_pops = 0;
   int uop_pct = 100;
   int exc_pct = 100;
   int rdy_pct = 100;
   bit exc_en = 1'b1;

   uop_entry_s src_uop[$];
   exc_info_s  src_exc[$];
   exc_info_s  m_exc[$];
   te_block_s  exp_q[$];
   te_block_s  got_q[$];

   bit        m_open = 1'b0;
   te_block_s m_blk;
   int        m_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: blocks follow from the uop stream alone.
   task automatic model_uop(input uop_entry_s u);
      int sz;
      te_block_s b;
      exc_info_s e;
      if (!u.valid) return;
      sz = u.compressed ? 1 : 2;
      if (m_open && (u.priv != m_blk.priv || m_cnt + sz > ILIM)) begin
         b = m_blk;
         b.iretire = 32'(m_cnt);
         b.itype = '0;
         exp_q.push_back(b);
         m_open = 1'b0;
      end
      if (!m_open) begin
         m_open = 1'b1;
         m_blk = '0;
         m_blk.iaddr = u.pc;
         m_blk.priv = u.priv;
         m_cnt = 0;
      end
      m_cnt += sz;
      m_blk.ilastsize = !u.compressed;
      if (u.itype != 0) begin
         b = m_blk;
         b.iretire = 32'(m_cnt);
         b.itype = u.itype;
         if (u.itype == 1 || u.itype == 2) begin
            e = m_exc.pop_front();
            b.cause = e.cause;
            b.tval = e.tval;
         end
         exp_q.push_back(b);
         m_open = 1'b0;
      end
   endtask

   task automatic add_uop(input logic v, input logic [31:0] pc,
                          input int it, input int pr, input logic c);
      uop_entry_s u;
      u = '0;
      u.valid = v;
      u.pc = XLEN'(pc);
      u.itype = ITYPE_LEN'(it);
      u.priv = PRIV_LEN'(pr);
      u.compressed = c;
      src_uop.push_back(u);
      model_uop(u);
   endtask

   task automatic add_exc(input logic [31:0] cause, input logic [31:0] tv);
      exc_info_s e;
      e.cause = XLEN'(cause);
      e.tval = XLEN'(tv);
      src_exc.push_back(e);
      m_exc.push_back(e);
   endtask

   task automatic drive();
      uop_valid_i = (src_uop.size() > 0) &&
                    ($urandom_range(99) < uop_pct);
      uop_entry_i = (src_uop.size() > 0) ? src_uop[0] : '0;
      exc_valid_i = exc_en && (src_exc.size() > 0) &&
                    ($urandom_range(99) < exc_pct);
      exc_info_i = (src_exc.size() > 0) ? src_exc[0] : '0;
      block_ready_i = $urandom_range(99) < rdy_pct;
   endtask

   task automatic check_block();
      te_block_s e;
      te_block_s g;
      g = '0;
      g.iaddr = iaddr_o;
      g.iretire = 32'(iretire_o);
      g.ilastsize = ilastsize_o;
      g.itype = itype_o;
      g.priv = priv_o;
      g.cause = cause_o;
      g.tval = tval_o;
      got_q.push_back(g);
      chk("blk_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      chk("iaddr", 64'(g.iaddr), 64'(e.iaddr));
      chk("iretire", 64'(g.iretire), 64'(e.iretire));
      chk("ilastsize", 64'(g.ilastsize), 64'(e.ilastsize));
      chk("itype", 64'(g.itype), 64'(e.itype));
      chk("priv", 64'(g.priv), 64'(e.priv));
      chk("cause", 64'(g.cause), 64'(e.cause));
      chk("tval", 64'(g.tval), 64'(e.tval));
   endtask

   task automatic tick();
      bit u_pop, e_pop;
      @(negedge clk_i);
      u_pop = uop_valid_i && uop_ready_o;
      e_pop = exc_valid_i && exc_ready_o;
      if (block_valid_o && block_ready_i) check_block();
      @(posedge clk_i);
      #1;
      if (u_pop) begin
         void'(src_uop.pop_front());
         uop_pops++;
      end
      if (e_pop) void'(src_exc.pop_front());
      drive();
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((src_uop.size() > 0 || exp_q.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_blocks_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 30 && !block_valid_o; i++) tick();
      chk(tag, 64'(block_valid_o), 64'd1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_bvalid"}, 64'(block_valid_o), 64'd0);
      chk({tag, "_eready"}, 64'(exc_ready_o), 64'd0);
      chk({tag, "_uready"}, 64'(uop_ready_o), 64'd1);
      chk({tag, "_iaddr"}, 64'(iaddr_o), 64'd0);
      chk({tag, "_iretire"}, 64'(iretire_o), 64'd0);
      chk({tag, "_itype"}, 64'(itype_o), 64'd0);
      chk({tag, "_cause"}, 64'(cause_o), 64'd0);
      chk({tag, "_tval"}, 64'(tval_o), 64'd0);
   endtask

   initial begin
      logic [XLEN-1:0] s_iaddr;
      logic [IRL-1:0]  s_iret;
      logic [ITYPE_LEN-1:0] s_itype;
      int pops0;
      int pr;
      int r;
      int it;

      rst_ni = 1'b0;
      uop_valid_i = 1'b0;
      uop_entry_i = '0;
      exc_valid_i = 1'b0;
      exc_info_i = '0;
      block_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_idle_outputs("reset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      drive();

      // Three STD uops closed by a taken branch.
      got_q.delete();
      add_uop(1, 32'h100, 0, 3, 0);
      add_uop(1, 32'h104, 0, 3, 1);
      add_uop(1, 32'h106, 0, 3, 0);
      add_uop(1, 32'h10A, 5, 3, 0);
      drain("t1", 200);
      chk("t1_nblk", 64'(got_q.size()), 64'd1);
      chk("t1_iaddr", 64'(got_q[0].iaddr), 64'h100);
      chk("t1_iret", 64'(got_q[0].iretire), 64'd7);
      chk("t1_last", 64'(got_q[0].ilastsize), 64'd1);
      chk("t1_itype", 64'(got_q[0].itype), 64'd5);

      // Exception block waits for the exc FIFO.
      got_q.delete();
      exc_en = 1'b0;
      add_exc(32'h2, 32'hDEAD);
      add_uop(1, 32'h200, 1, 3, 0);
      repeat (3) tick();
      for (int i = 0; i < 5; i++) begin
         chk("t2_exc_ready", 64'(exc_ready_o), 64'd1);
         chk("t2_no_block", 64'(block_valid_o), 64'd0);
         tick();
      end
      exc_en = 1'b1;
      drain("t2", 200);
      chk("t2_cause", 64'(got_q[0].cause), 64'h2);
      chk("t2_tval", 64'(got_q[0].tval), 64'hDEAD);
      chk("t2_iret", 64'(got_q[0].iretire), 64'd2);

      // Privilege change forces a close; pending uop opens the next.
      got_q.delete();
      pops0 = uop_pops;
      add_uop(1, 32'h300, 0, 3, 0);
      add_uop(1, 32'h80, 0, 0, 0);
      add_uop(1, 32'h84, 5, 0, 0);
      drain("t3", 200);
      chk("t3_pops", 64'(uop_pops - pops0), 64'd3);
      chk("t3_iaddr0", 64'(got_q[0].iaddr), 64'h300);
      chk("t3_itype0", 64'(got_q[0].itype), 64'd0);
      chk("t3_priv0", 64'(got_q[0].priv), 64'd3);
      chk("t3_iaddr1", 64'(got_q[1].iaddr), 64'h80);
      chk("t3_priv1", 64'(got_q[1].priv), 64'd0);

      // Counter limit (15 half-words) forces a close.
      got_q.delete();
      for (int i = 0; i < 8; i++) add_uop(1, 32'h400 + 4 * i, 0, 0, 0);
      add_uop(1, 32'h420, 13, 0, 0);
      drain("t4", 300);
      chk("t4_iret0", 64'(got_q[0].iretire), 64'd14);
      chk("t4_itype0", 64'(got_q[0].itype), 64'd0);
      chk("t4_iret1", 64'(got_q[1].iretire), 64'd4);
      chk("t4_itype1", 64'(got_q[1].itype), 64'd13);
      chk("t4_iaddr1", 64'(got_q[1].iaddr), 64'h41C);

      // Encoder stall: outputs hold, no pops.
      rdy_pct = 0;
      add_uop(1, 32'h500, 0, 1, 1);
      add_uop(1, 32'h502, 5, 1, 0);
      add_uop(1, 32'h600, 0, 1, 0);
      add_uop(1, 32'h604, 13, 1, 1);
      wait_valid("t5_valid");
      s_iaddr = iaddr_o;
      s_iret = iretire_o;
      s_itype = itype_o;
      pops0 = uop_pops;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t5_hold_valid", 64'(block_valid_o), 64'd1);
         chk("t5_hold_iaddr", 64'(iaddr_o), 64'(s_iaddr));
         chk("t5_hold_iret", 64'(iretire_o), 64'(s_iret));
         chk("t5_hold_itype", 64'(itype_o), 64'(s_itype));
         chk("t5_uready", 64'(uop_ready_o), 64'd0);
         chk("t5_no_pop", 64'(uop_pops), 64'(pops0));
      end
      rdy_pct = 100;
      drain("t5", 200);

      // Async reset during EMIT drops the block.
      rdy_pct = 0;
      add_uop(1, 32'h700, 0, 2, 0);
      add_uop(1, 32'h704, 5, 2, 0);
      wait_valid("t6_valid");
      #2;
      rst_ni = 1'b0;
      #1;
      chk_idle_outputs("t6_rst");
      src_uop.delete();
      src_exc.delete();
      m_exc.delete();
      exp_q.delete();
      m_open = 1'b0;
      rdy_pct = 100;
      drive();
      @(negedge clk_i);
      rst_ni = 1'b1;
      got_q.delete();
      add_uop(1, 32'h800, 0, 1, 1);
      add_uop(1, 32'h802, 5, 1, 0);
      drain("t6", 200);
      chk("t6_iaddr", 64'(got_q[0].iaddr), 64'h800);
      chk("t6_iret", 64'(got_q[0].iretire), 64'd3);

      // Random streams with random handshake pressure.
      uop_pct = 40 + $urandom_range(60);
      exc_pct = 40 + $urandom_range(60);
      rdy_pct = 40 + $urandom_range(60);
      pr = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(99) < 8) pr = $urandom_range(3);
         r = $urandom_range(99);
         it = (r < 70) ? 0 : (r < 76) ? 1 : (r < 80) ? 2 :
              (r < 85) ? 5 : (r < 90) ? 13 : (r < 95) ? 4 : 3;
         if (it == 1 || it == 2) add_exc($urandom, $urandom);
         add_uop(logic'($urandom_range(99) < 92),
                 $urandom & 32'hFFFF_FFFE, it, pr,
                 logic'($urandom_range(1)));
      end
      add_uop(1, 32'h900, 5, pr, 0);
      drain("rand", 20000);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
